reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
- Write-side controller for the 16x16 register file. It merges ALU results and memory-load results onto the file's single write port (write enable, destination address, write data).
- Buffers load returns in a small FIFO and keeps a per-register pending scoreboard of outstanding loads.
- Issue logic uses the scoreboard to detect read-after-load and write-after-load hazards.
- Sits between the execute/memory stages and the register file's write port.

Parameters:
SIZE, 16, data width of one register
REGBITS, 4, register address width (file holds 2^REGBITS registers)
LDQ_DEPTH, 2, load-return FIFO depth (power of two, at least 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result present this cycle (always accepted)
alu_dst  input  REGBITS  ALU destination register
alu_data  input  SIZE  ALU result
ld_valid  input  1  load return valid
ld_ready  output  1  controller can accept a load return
ld_dst  input  REGBITS  load destination register
ld_data  input  SIZE  load data
issue_ld  input  1  a load is being issued this cycle
issue_dst  input  REGBITS  destination of the issued load
chk_addr1  input  REGBITS  source operand 1 to hazard-check
chk_addr2  input  REGBITS  source operand 2 (or destination) to hazard-check
hazard  output  1  chk_addr1 or chk_addr2 has a pending load
pending  output  2^REGBITS  scoreboard vector, bit r set = load outstanding to register r
rf_writeEn  output  1  register file write enable
rf_dstAddr  output  REGBITS  register file write address
rf_writeData  output  SIZE  register file write data

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high.
- Reset values:
  - rf_writeEn=0, rf_dstAddr=0, rf_writeData=0.
  - pending=0, FIFO empty, ld_ready=0 while reset is high.
  - Reset mid-operation discards queued loads and clears all pending bits.
- Output timing:
  - The rf_* outputs are registered: a result selected in cycle N appears on rf_* in cycle N+1, and the register file captures it at the end of N+1.
  - hazard and ld_ready are combinational.
- Load handshake:
  - A load return transfers when ld_valid && ld_ready.
  - ld_ready = !fifo_full && !reset.
  - ld_valid without ld_ready: the source holds dst and data stable.
- Arbitration, evaluated each cycle:
  - If alu_valid: select the ALU result. The FIFO is not popped.
  - Else, if the FIFO is non-empty: pop the head and select it.
  - Else, if a load is transferring this cycle: bypass it directly, with no FIFO entry.
  - Else: nothing selected, so rf_writeEn=0 next cycle.
- FIFO:
  - A push and a pop in the same cycle is legal when the FIFO is full: count stays the same and ld_ready stays 0 for that cycle.
  - Pointers wrap modulo LDQ_DEPTH.
  - Entries leave in arrival order.
- Scoreboard:
  - issue_ld sets pending[issue_dst] at the clock edge.
  - A selected load result clears pending[dst] at the same edge it is selected.
  - Set and clear of the same register in the same cycle: set wins (a new load is outstanding).
  - An ALU write does not modify pending.
  - issue_ld to an already-pending register is a protocol violation. The bit stays set; simulation-only assertion.
- hazard = pending[chk_addr1] | pending[chk_addr2].
- ALU starvation: a continuous ALU stream starves loads. The FIFO fills, ld_ready drops, and the memory side stalls.
- Ordering guarantee: issue logic stalls on hazard (with the destination placed on chk_addr2), so an ALU write never targets a pending register.
- No arithmetic is performed; data passes through unmodified.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined — adds three outputs:
  - fwd_hit1 (1 bit): rf_writeEn && rf_dstAddr==chk_addr1.
  - fwd_hit2 (1 bit): the same comparison against chk_addr2.
  - fwd_data (SIZE): equals rf_writeData.
  - Purpose: issue logic bypasses the register file's registered read latency.
  - hazard is unchanged.
- Undefined: these ports and their logic are absent. Issue logic inserts a one-cycle bubble instead.

Decomposition:
- Shared package (cpu_pkg): SIZE, REGBITS, LDQ_DEPTH defaults, and a wb_entry typedef {dst[REGBITS], data[SIZE]}.
- One sub-module: wb_load_fifo, parameterised depth FIFO of wb_entry with push/pop/full/empty. Arbitration and scoreboard stay in the top module.

Test Plan:
- Reset, then alu_valid=1, alu_dst=3, alu_data=16'h00A5 for one cycle -> next cycle rf_writeEn=1, rf_dstAddr=3, rf_writeData=16'h00A5; the cycle after that rf_writeEn=0.
- issue_ld with issue_dst=5, chk_addr1=5 -> hazard=1 and pending[5]=1. Then ld_valid with ld_dst=5, data 16'h1234, FIFO empty, no ALU -> rf write of 16'h1234 to r5 one cycle later, and pending[5]=0 in that same cycle.
- alu_valid held 4 cycles while two loads (r1=16'h0001, r2=16'h0002) arrive -> FIFO full and ld_ready=0. After the ALU stops: r1 written, then r2, on consecutive cycles with no gaps.
- Same cycle: issue_ld to r7 and the FIFO head load to r7 selected -> r7 written, and pending[7] stays 1.
- Reset asserted with 2 queued loads and pending=16'h0006 -> after reset rf_writeEn=0, pending=0, ld_ready=1, and no queued write appears.
- With WB_FORWARD_EN: ALU write to r4 with chk_addr2=4 -> fwd_hit2=1 and fwd_data equals the ALU data during the rf_writeEn cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU write-back definitions: default widths, FIFO depth and the
// load-return entry type.
package cpu_pkg;

   localparam int SIZE      = 16;
   localparam int REGBITS   = 4;
   localparam int LDQ_DEPTH = 2;

   typedef struct packed {
      logic [REGBITS-1:0] dst;
      logic [SIZE-1:0]    data;
   } wb_entry;

endpackage

// File: rtl/wb_load_fifo.sv
// Small in-order FIFO that buffers load returns awaiting the register file
// write port. DEPTH must be a power of two so pointers wrap naturally.
module wb_load_fifo
   import cpu_pkg::*;
#(
   parameter type T     = wb_entry,
   parameter int  DEPTH = LDQ_DEPTH
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T               mem_q [DEPTH];
   logic [AW-1:0]  wr_q;
   logic [AW-1:0]  rd_q;
   logic [CW-1:0]  cnt_q;
   logic           do_push;
   logic           do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign dout    = mem_q[rd_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage array: written at the tail, never reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register file write-port controller: ALU/load arbitration and pending-load
// scoreboard. Define WB_FORWARD_EN to add the fwd_hit1/fwd_hit2/fwd_data outputs.
module reg_writeback_ctrl
#(
   parameter int SIZE      = cpu_pkg::SIZE,
   parameter int REGBITS   = cpu_pkg::REGBITS,
   parameter int LDQ_DEPTH = cpu_pkg::LDQ_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [REGBITS-1:0]    alu_dst,
   input  logic [SIZE-1:0]       alu_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REGBITS-1:0]    ld_dst,
   input  logic [SIZE-1:0]       ld_data,
   input  logic                  issue_ld,
   input  logic [REGBITS-1:0]    issue_dst,
   input  logic [REGBITS-1:0]    chk_addr1,
   input  logic [REGBITS-1:0]    chk_addr2,
   output logic                  hazard,
   output logic [2**REGBITS-1:0] pending,
   output logic                  rf_writeEn,
   output logic [REGBITS-1:0]    rf_dstAddr,
   output logic [SIZE-1:0]       rf_writeData
`ifdef WB_FORWARD_EN
   ,
   output logic                  fwd_hit1,
   output logic                  fwd_hit2,
   output logic [SIZE-1:0]       fwd_data
`endif
);

   import cpu_pkg::*;

   localparam int NREG = 2**REGBITS;

   typedef struct packed {
      logic [REGBITS-1:0] dst;
      logic [SIZE-1:0]    data;
   } entry_t;

   entry_t             ld_in;
   entry_t             head;
   logic               full;
   logic               empty;
   logic               xfer;
   logic               push;
   logic               pop;
   logic               sel_v;
   logic               sel_ld;
   logic [REGBITS-1:0] sel_dst;
   logic [SIZE-1:0]    sel_data;
   logic [NREG-1:0]    clr_vec;
   logic [NREG-1:0]    set_vec;
   logic [NREG-1:0]    pending_d;
   logic [NREG-1:0]    pending_q;
   logic               we_q;
   logic [REGBITS-1:0] dst_q;
   logic [SIZE-1:0]    data_q;

   assign ld_ready = !full && !reset;
   assign xfer     = ld_valid && ld_ready;
   assign ld_in    = '{dst: ld_dst, data: ld_data};

   wb_load_fifo #(
      .T     (entry_t),
      .DEPTH (LDQ_DEPTH)
   ) u_ldq (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (ld_in),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Write-port arbitration: ALU first, then queued loads, then bypass.
   always_comb begin
      push     = xfer;
      pop      = 1'b0;
      sel_v    = 1'b0;
      sel_ld   = 1'b0;
      sel_dst  = alu_dst;
      sel_data = alu_data;
      if (alu_valid) begin
         sel_v = 1'b1;
      end else if (!empty) begin
         pop      = 1'b1;
         sel_v    = 1'b1;
         sel_ld   = 1'b1;
         sel_dst  = head.dst;
         sel_data = head.data;
      end else if (xfer) begin
         push     = 1'b0;
         sel_v    = 1'b1;
         sel_ld   = 1'b1;
         sel_dst  = ld_dst;
         sel_data = ld_data;
      end
   end

   // Scoreboard next state: a new issue overrides a same-cycle clear.
   always_comb begin
      clr_vec   = sel_ld ? (NREG'(1) << sel_dst) : '0;
      set_vec   = issue_ld ? (NREG'(1) << issue_dst) : '0;
      pending_d = (pending_q & ~clr_vec) | set_vec;
   end

   // Registered write port and scoreboard state.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q      <= 1'b0;
         dst_q     <= '0;
         data_q    <= '0;
         pending_q <= '0;
      end else begin
         we_q      <= sel_v;
         pending_q <= pending_d;
         if (sel_v) begin
            dst_q  <= sel_dst;
            data_q <= sel_data;
         end
      end
   end

   // Re-issuing to a register whose load is still outstanding is illegal.
   a_reissue: assert property (@(posedge clk) disable iff (reset)
      issue_ld |-> (!pending_q[issue_dst] || clr_vec[issue_dst]));

   assign hazard       = pending_q[chk_addr1] | pending_q[chk_addr2];
   assign pending      = pending_q;
   assign rf_writeEn   = we_q;
   assign rf_dstAddr   = dst_q;
   assign rf_writeData = data_q;

`ifdef WB_FORWARD_EN
   assign fwd_hit1 = we_q && (dst_q == chk_addr1);
   assign fwd_hit2 = we_q && (dst_q == chk_addr2);
   assign fwd_data = data_q;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: arbitration, FIFO ordering,
// scoreboard and reset behaviour with hand-computed expectations.
module tb_reg_writeback_ctrl;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [3:0]  alu_dst;
   logic [15:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_dst;
   logic [15:0] ld_data;
   logic        issue_ld;
   logic [3:0]  issue_dst;
   logic [3:0]  chk_addr1;
   logic [3:0]  chk_addr2;
   logic        hazard;
   logic [15:0] pending;
   logic        rf_writeEn;
   logic [3:0]  rf_dstAddr;
   logic [15:0] rf_writeData;
`ifdef WB_FORWARD_EN
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [15:0] fwd_data;
`endif

   int total;
   int bad;

   reg_writeback_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_dst      (alu_dst),
      .alu_data     (alu_data),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_dst       (ld_dst),
      .ld_data      (ld_data),
      .issue_ld     (issue_ld),
      .issue_dst    (issue_dst),
      .chk_addr1    (chk_addr1),
      .chk_addr2    (chk_addr2),
      .hazard       (hazard),
      .pending      (pending),
      .rf_writeEn   (rf_writeEn),
      .rf_dstAddr   (rf_dstAddr),
      .rf_writeData (rf_writeData)
`ifdef WB_FORWARD_EN
      ,
      .fwd_hit1     (fwd_hit1),
      .fwd_hit2     (fwd_hit2),
      .fwd_data     (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input string tag, input logic [3:0] d,
                     input logic [15:0] v);
      chk({tag, "_we"}, 32'(rf_writeEn), 32'd1);
      chk({tag, "_dst"}, 32'(rf_dstAddr), 32'(d));
      chk({tag, "_data"}, 32'(rf_writeData), 32'(v));
   endtask

   task automatic nxt;
      @(negedge clk);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      alu_valid = 1'b0;
      alu_dst   = '0;
      alu_data  = '0;
      ld_valid  = 1'b0;
      ld_dst    = '0;
      ld_data   = '0;
      issue_ld  = 1'b0;
      issue_dst = '0;
      chk_addr1 = '0;
      chk_addr2 = '0;

      // reset state
      nxt;
      nxt;
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_we", 32'(rf_writeEn), 32'd0);
      chk("rst_dst", 32'(rf_dstAddr), 32'd0);
      chk("rst_data", 32'(rf_writeData), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      reset = 1'b0;
      #1 chk("post_rst_ready", 32'(ld_ready), 32'd1);

      // single ALU write
      alu_valid = 1'b1;
      alu_dst   = 4'd3;
      alu_data  = 16'h00A5;
      nxt;
      wr("alu3", 4'd3, 16'h00A5);
      alu_valid = 1'b0;
      nxt;
      chk("alu3_off", 32'(rf_writeEn), 32'd0);

      // issue load r5, hazard, then bypassed return
      issue_ld  = 1'b1;
      issue_dst = 4'd5;
      chk_addr1 = 4'd5;
      #1 chk("haz_before", 32'(hazard), 32'd0);
      nxt;
      issue_ld = 1'b0;
      chk("pend5", 32'(pending), 32'h0020);
      chk("haz5_a1", 32'(hazard), 32'd1);
      chk_addr1 = 4'd0;
      chk_addr2 = 4'd5;
      #1 chk("haz5_a2", 32'(hazard), 32'd1);
      chk_addr2 = 4'd6;
      #1 chk("haz_none", 32'(hazard), 32'd0);
      ld_valid = 1'b1;
      ld_dst   = 4'd5;
      ld_data  = 16'h1234;
      #1 chk("byp_ready", 32'(ld_ready), 32'd1);
      nxt;
      wr("byp5", 4'd5, 16'h1234);
      chk("byp5_pend", 32'(pending), 32'd0);
      ld_valid = 1'b0;
      nxt;
      chk("byp5_off", 32'(rf_writeEn), 32'd0);

      // starvation: ALU stream while two loads queue up
      issue_ld  = 1'b1;
      issue_dst = 4'd1;
      nxt;
      issue_dst = 4'd2;
      nxt;
      issue_ld = 1'b0;
      chk("pend12", 32'(pending), 32'h0006);
      alu_valid = 1'b1;
      alu_dst   = 4'd9;
      alu_data  = 16'h0900;
      ld_valid  = 1'b1;
      ld_dst    = 4'd1;
      ld_data   = 16'h0001;
      nxt;
      wr("stv_alu0", 4'd9, 16'h0900);
      alu_data = 16'h0901;
      ld_dst   = 4'd2;
      ld_data  = 16'h0002;
      #1 chk("stv_ready1", 32'(ld_ready), 32'd1);
      nxt;
      ld_valid = 1'b0;
      alu_data = 16'h0902;
      chk("stv_full", 32'(ld_ready), 32'd0);
      nxt;
      alu_data = 16'h0903;
      chk("stv_full2", 32'(ld_ready), 32'd0);
      nxt;
      wr("stv_alu3", 4'd9, 16'h0903);
      chk("stv_pend", 32'(pending), 32'h0006);
      chk("stv_full3", 32'(ld_ready), 32'd0);
      alu_valid = 1'b0;
      nxt;
      wr("drain_r1", 4'd1, 16'h0001);
      chk("drain_pend1", 32'(pending), 32'h0004);
      chk("drain_ready", 32'(ld_ready), 32'd1);
      nxt;
      wr("drain_r2", 4'd2, 16'h0002);
      chk("drain_pend2", 32'(pending), 32'd0);
      nxt;
      chk("drain_off", 32'(rf_writeEn), 32'd0);

      // same-cycle set and clear of r7
      issue_ld  = 1'b1;
      issue_dst = 4'd7;
      nxt;
      issue_ld  = 1'b0;
      alu_valid = 1'b1;
      alu_dst   = 4'd10;
      alu_data  = 16'h0A0A;
      ld_valid  = 1'b1;
      ld_dst    = 4'd7;
      ld_data   = 16'h0777;
      nxt;
      wr("r7_alu", 4'd10, 16'h0A0A);
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      issue_ld  = 1'b1;
      issue_dst = 4'd7;
      nxt;
      wr("r7_head", 4'd7, 16'h0777);
      chk("r7_pend", 32'(pending), 32'h0080);
      issue_ld = 1'b0;
      ld_valid = 1'b1;
      ld_data  = 16'h0778;
      nxt;
      wr("r7_second", 4'd7, 16'h0778);
      chk("r7_clr", 32'(pending), 32'd0);
      ld_valid = 1'b0;

      // reset with two queued loads
      issue_ld  = 1'b1;
      issue_dst = 4'd1;
      nxt;
      issue_dst = 4'd2;
      nxt;
      issue_ld  = 1'b0;
      alu_valid = 1'b1;
      alu_dst   = 4'd11;
      alu_data  = 16'h0B0B;
      ld_valid  = 1'b1;
      ld_dst    = 4'd1;
      ld_data   = 16'h0011;
      nxt;
      ld_dst  = 4'd2;
      ld_data = 16'h0022;
      nxt;
      chk("mid_pend", 32'(pending), 32'h0006);
      chk("mid_full", 32'(ld_ready), 32'd0);
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      reset     = 1'b1;
      nxt;
      chk("mid_rst_we", 32'(rf_writeEn), 32'd0);
      chk("mid_rst_pend", 32'(pending), 32'd0);
      reset = 1'b0;
      #1 chk("mid_rst_ready", 32'(ld_ready), 32'd1);
      nxt;
      chk("mid_rst_q0", 32'(rf_writeEn), 32'd0);
      nxt;
      chk("mid_rst_q1", 32'(rf_writeEn), 32'd0);

`ifdef WB_FORWARD_EN
      // forwarding match on operand 2
      alu_valid = 1'b1;
      alu_dst   = 4'd4;
      alu_data  = 16'h4444;
      chk_addr1 = 4'd0;
      chk_addr2 = 4'd4;
      nxt;
      alu_valid = 1'b0;
      chk("fwd_hit2", 32'(fwd_hit2), 32'd1);
      chk("fwd_hit1", 32'(fwd_hit1), 32'd0);
      chk("fwd_data", 32'(fwd_data), 32'h4444);
      nxt;
      chk("fwd_hit2_off", 32'(fwd_hit2), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
